// File: rtl/cell_to_pixel_mover.sv
// Walks a sprite from its pixel position to a requested maze cell, x axis first, then y.
// One step per move_tick; done comes 4 cycles after acceptance for a zero-length move; req_ready is low until IDLE.
module cell_to_pixel_mover #(
  parameter logic [9:0] SF       = 10'd60,
  parameter logic [9:0] S_X      = 10'd150,
  parameter logic [9:0] S_Y      = 10'd34,
  parameter int         NUM_COLS = 8,
  parameter int         NUM_ROWS = 8,
  parameter logic [9:0] STEP     = 10'd1,
  parameter int         HOME_ROW = 0,
  parameter int         HOME_COL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_tick,
  input  logic       req_valid,
  input  logic [7:0] req_row,
  input  logic [7:0] req_col,
  input  logic       abort,
  output logic       req_ready,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic [3:0] direction,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, CALC, MOVE_X, MOVE_Y, DONE} state_t;

  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;
  localparam logic [3:0] DIR_0 = 4'b0000;
  localparam logic [9:0] HOME_X  = 10'(S_X + HOME_COL * SF);
  localparam logic [9:0] HOME_Y  = 10'(S_Y + HOME_ROW * SF);
  localparam logic [8:0] ROW_LIM = 9'(NUM_ROWS);
  localparam logic [8:0] COL_LIM = 9'(NUM_COLS);

  state_t     state_q;
  logic [7:0] row_q, col_q;
  logic [9:0] tx_q, ty_q, xpos_q, ypos_q;
  logic [3:0] dir_q;
  logic       done_q, err_q, ready_q;

  logic [9:0] tx_d, ty_d, dx, dy, xpos_d, ypos_d;
  logic       bad_cell;

  // Pixel targets wrap modulo 1024 on purpose: the arithmetic is defined as 10-bit.
  assign tx_d     = S_X + {2'b00, col_q} * SF;
  assign ty_d     = S_Y + {2'b00, row_q} * SF;
  assign bad_cell = ({1'b0, row_q} >= ROW_LIM) || ({1'b0, col_q} >= COL_LIM);

  // Step is clamped to the remaining distance, so the target is never overshot.
  assign dx     = (tx_q > xpos_q) ? tx_q - xpos_q : xpos_q - tx_q;
  assign dy     = (ty_q > ypos_q) ? ty_q - ypos_q : ypos_q - ty_q;
  assign xpos_d = (tx_q > xpos_q) ? xpos_q + ((dx < STEP) ? dx : STEP)
                                  : xpos_q - ((dx < STEP) ? dx : STEP);
  assign ypos_d = (ty_q > ypos_q) ? ypos_q + ((dy < STEP) ? dy : STEP)
                                  : ypos_q - ((dy < STEP) ? dy : STEP);

  function automatic logic [3:0] dir_of(input logic [9:0] pos, input logic [9:0] tgt,
                                        input logic [3:0] dir_lo, input logic [3:0] dir_hi);
    if (pos == tgt)     return DIR_0;
    else if (tgt < pos) return dir_lo;
    else                return dir_hi;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= 8'd0;
      col_q   <= 8'd0;
      tx_q    <= HOME_X;
      ty_q    <= HOME_Y;
      xpos_q  <= HOME_X;
      ypos_q  <= HOME_Y;
      dir_q   <= DIR_0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            row_q   <= req_row;
            col_q   <= req_col;
            ready_q <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else if (bad_cell) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            dir_q   <= dir_of(xpos_q, tx_d, DIR_L, DIR_R);
            state_q <= MOVE_X;
          end
        end
        MOVE_X: begin
          if (abort) begin
            dir_q   <= DIR_0;
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else if (xpos_q == tx_q) begin
            dir_q   <= dir_of(ypos_q, ty_q, DIR_U, DIR_D);
            state_q <= MOVE_Y;
          end else if (move_tick) begin
            xpos_q <= xpos_d;
            dir_q  <= dir_of(xpos_d, tx_q, DIR_L, DIR_R);
          end
        end
        MOVE_Y: begin
          if (abort) begin
            dir_q   <= DIR_0;
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else if (ypos_q == ty_q) begin
            dir_q   <= DIR_0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (move_tick) begin
            ypos_q <= ypos_d;
            dir_q  <= dir_of(ypos_d, ty_q, DIR_U, DIR_D);
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          dir_q   <= DIR_0;
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign direction = dir_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cell_to_pixel_mover.sv
// Directed bench: one default instance (STEP=1) and one with STEP=7 for the clamped-final-step case.
module tb_cell_to_pixel_mover;

  logic       clk, rst_n, move_tick, abort;
  logic       req_valid, rv7;
  logic [7:0] req_row, req_col, rr7, rc7;
  logic       req_ready, done, err, ready7, done7, err7;
  logic [9:0] xpos, ypos, xpos7, ypos7;
  logic [3:0] direction, dir7;

  int n_cmp = 0;
  int n_bad = 0;

  cell_to_pixel_mover dut (
    .clk(clk), .rst_n(rst_n), .move_tick(move_tick), .req_valid(req_valid),
    .req_row(req_row), .req_col(req_col), .abort(abort), .req_ready(req_ready),
    .xpos(xpos), .ypos(ypos), .direction(direction), .done(done), .err(err)
  );

  cell_to_pixel_mover #(.STEP(10'd7)) dut7 (
    .clk(clk), .rst_n(rst_n), .move_tick(move_tick), .req_valid(rv7),
    .req_row(rr7), .req_col(rc7), .abort(abort), .req_ready(ready7),
    .xpos(xpos7), .ypos(ypos7), .direction(dir7), .done(done7), .err(err7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (xpos !== 10'd150) begin n_bad++; $display("FAIL reset_xpos got %0d want 150", xpos); end
    n_cmp++; if (ypos !== 10'd34) begin n_bad++; $display("FAIL reset_ypos got %0d want 34", ypos); end
    n_cmp++; if (direction !== 4'b0000) begin n_bad++; $display("FAIL reset_dir got %b want 0000", direction); end
    n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got done=%b err=%b want 0 0", done, err); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", req_ready); end
    rst_n = 1'b1;
  endtask

  // (2,3): x 150->330 then y 34->154, one pixel per tick, done 304 cycles after acceptance.
  task automatic test_move_23();
    int dir_r, dir_d, bad_step, done_cnt, done_n, rdy_bad;
    logic [9:0] px, py;
    dir_r = 0; dir_d = 0; bad_step = 0; done_cnt = 0; done_n = -1; rdy_bad = 0;
    move_tick = 1'b1;
    @(negedge clk);
    req_row = 8'd2; req_col = 8'd3; req_valid = 1'b1;
    px = xpos; py = ypos;
    for (int n = 1; n <= 320; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (n == 1 && req_ready !== 1'b0) rdy_bad++;
      if (direction == 4'b0010) dir_r++;
      if (direction == 4'b0001) dir_d++;
      if (done) begin done_cnt++; if (done_n < 0) done_n = n; end
      if (xpos != px && !(xpos == px + 10'd1 && ypos == py)) bad_step++;
      if (ypos != py && !(ypos == py + 10'd1 && xpos == px)) bad_step++;
      px = xpos; py = ypos;
    end
    n_cmp++; if (rdy_bad != 0) begin n_bad++; $display("FAIL move23_ready_low got %0d highs want 0", rdy_bad); end
    n_cmp++; if (xpos !== 10'd330) begin n_bad++; $display("FAIL move23_xpos got %0d want 330", xpos); end
    n_cmp++; if (ypos !== 10'd154) begin n_bad++; $display("FAIL move23_ypos got %0d want 154", ypos); end
    n_cmp++; if (dir_r != 180) begin n_bad++; $display("FAIL move23_dir_right_cycles got %0d want 180", dir_r); end
    n_cmp++; if (dir_d != 120) begin n_bad++; $display("FAIL move23_dir_down_cycles got %0d want 120", dir_d); end
    n_cmp++; if (bad_step != 0) begin n_bad++; $display("FAIL move23_step_shape got %0d bad steps want 0", bad_step); end
    n_cmp++; if (done_cnt != 1 || done_n != 304) begin n_bad++; $display("FAIL move23_done got count=%0d at=%0d want 1 at 304", done_cnt, done_n); end
  endtask

  // STEP=7: to (2,3) and back to (0,0); last steps must clamp to 5 (x) and 1 (y).
  task automatic test_step7();
    int dl, du, dcnt, ecnt, lastx, lasty, big, over;
    logic [9:0] px, py;
    logic seen;
    dl = 0; du = 0; dcnt = 0; ecnt = 0; lastx = 0; lasty = 0; big = 0; over = 0;
    move_tick = 1'b1;
    @(negedge clk);
    rr7 = 8'd2; rc7 = 8'd3; rv7 = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      rv7 = 1'b0;
      if (done7) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1 || xpos7 !== 10'd330 || ypos7 !== 10'd154) begin
      n_bad++; $display("FAIL step7_outbound got done=%b x=%0d y=%0d want 1 330 154", seen, xpos7, ypos7); end
    @(negedge clk);
    n_cmp++; if (ready7 !== 1'b1) begin n_bad++; $display("FAIL step7_ready got %b want 1", ready7); end
    rr7 = 8'd0; rc7 = 8'd0; rv7 = 1'b1;
    px = xpos7; py = ypos7;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      rv7 = 1'b0;
      if (dir7 == 4'b1000) dl++;
      if (dir7 == 4'b0100) du++;
      if (done7) dcnt++;
      if (err7) ecnt++;
      if (xpos7 != px) begin
        if (xpos7 > px || xpos7 < 10'd150) over++;
        else begin lastx = int'(px - xpos7); if (lastx > 7) big++; end
      end
      if (ypos7 != py) begin
        if (ypos7 > py || ypos7 < 10'd34) over++;
        else begin lasty = int'(py - ypos7); if (lasty > 7) big++; end
      end
      px = xpos7; py = ypos7;
    end
    n_cmp++; if (lastx != 5) begin n_bad++; $display("FAIL step7_last_x_step got %0d want 5", lastx); end
    n_cmp++; if (lasty != 1) begin n_bad++; $display("FAIL step7_last_y_step got %0d want 1", lasty); end
    n_cmp++; if (over != 0 || big != 0) begin n_bad++; $display("FAIL step7_overshoot got over=%0d big=%0d want 0 0", over, big); end
    n_cmp++; if (xpos7 !== 10'd150 || ypos7 !== 10'd34) begin n_bad++; $display("FAIL step7_final got %0d,%0d want 150,34", xpos7, ypos7); end
    n_cmp++; if (dl != 26 || du != 18) begin n_bad++; $display("FAIL step7_dirs got left=%0d up=%0d want 26 18", dl, du); end
    n_cmp++; if (dcnt != 1 || ecnt != 0) begin n_bad++; $display("FAIL step7_pulses got done=%0d err=%0d want 1 0", dcnt, ecnt); end
  endtask

  task automatic test_err();
    logic [7:0] rows [2];
    logic [7:0] cols [2];
    int en, ecnt, dcnt, moved;
    rows[0] = 8'd8; cols[0] = 8'd0;
    rows[1] = 8'd0; cols[1] = 8'd200;
    move_tick = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      req_row = rows[t]; req_col = cols[t]; req_valid = 1'b1;
      en = -1; ecnt = 0; dcnt = 0; moved = 0;
      for (int n = 1; n <= 6; n++) begin
        @(negedge clk);
        req_valid = 1'b0;
        if (err) begin ecnt++; if (en < 0) en = n; end
        if (done) dcnt++;
        if (xpos !== 10'd330 || ypos !== 10'd154 || direction !== 4'b0000) moved++;
      end
      n_cmp++; if (ecnt != 1 || en != 2) begin n_bad++; $display("FAIL err_pulse_%0d got count=%0d at=%0d want 1 at 2", t, ecnt, en); end
      n_cmp++; if (dcnt != 0 || moved != 0) begin n_bad++; $display("FAIL err_quiet_%0d got done=%0d moved=%0d want 0 0", t, dcnt, moved); end
    end
  endtask

  task automatic test_same_cell();
    int dn, dcnt, moved;
    dn = -1; dcnt = 0; moved = 0;
    @(negedge clk);
    req_row = 8'd2; req_col = 8'd3; req_valid = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (done) begin dcnt++; if (dn < 0) dn = n; end
      if (xpos !== 10'd330 || ypos !== 10'd154 || direction !== 4'b0000) moved++;
    end
    n_cmp++; if (dcnt != 1 || dn != 4) begin n_bad++; $display("FAIL same_cell_done got count=%0d at=%0d want 1 at 4", dcnt, dn); end
    n_cmp++; if (moved != 0) begin n_bad++; $display("FAIL same_cell_still got %0d moving cycles want 0", moved); end
  endtask

  // Heading left to (0,0): a stray request at x=250 is ignored, abort lands at x=200.
  task automatic test_abort();
    logic found;
    int dcnt, moved;
    found = 1'b0; dcnt = 0; moved = 0;
    move_tick = 1'b1;
    @(negedge clk);
    req_row = 8'd0; req_col = 8'd0; req_valid = 1'b1;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (xpos == 10'd250) begin req_row = 8'd5; req_col = 8'd5; req_valid = 1'b1; end
      if (xpos == 10'd200) begin abort = 1'b1; found = 1'b1; end
    end
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (found !== 1'b1 || xpos !== 10'd200) begin n_bad++; $display("FAIL abort_hold_x got found=%b x=%0d want 1 200", found, xpos); end
    n_cmp++; if (req_ready !== 1'b1 || direction !== 4'b0000) begin n_bad++; $display("FAIL abort_idle got ready=%b dir=%b want 1 0000", req_ready, direction); end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (xpos !== 10'd200 || ypos !== 10'd154) moved++;
    end
    n_cmp++; if (dcnt != 0 || moved != 0) begin n_bad++; $display("FAIL abort_after got done=%0d moved=%0d want 0 0", dcnt, moved); end
  endtask

  task automatic test_reset_mid();
    int dcnt, moved;
    dcnt = 0; moved = 0;
    move_tick = 1'b1;
    @(negedge clk);
    req_row = 8'd7; req_col = 8'd7; req_valid = 1'b1;
    repeat (20) begin @(negedge clk); req_valid = 1'b0; end
    n_cmp++; if (xpos === 10'd200) begin n_bad++; $display("FAIL rstmid_moving got x=%0d want not 200", xpos); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (xpos !== 10'd150 || ypos !== 10'd34) begin n_bad++; $display("FAIL rstmid_async_pos got %0d,%0d want 150,34", xpos, ypos); end
    n_cmp++; if (req_ready !== 1'b1 || direction !== 4'b0000) begin n_bad++; $display("FAIL rstmid_async_ctrl got ready=%b dir=%b want 1 0000", req_ready, direction); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (xpos !== 10'd150 || ypos !== 10'd34) moved++;
    end
    n_cmp++; if (dcnt != 0 || moved != 0) begin n_bad++; $display("FAIL rstmid_after got done=%0d moved=%0d want 0 0", dcnt, moved); end
  endtask

  initial begin
    rst_n = 1'b1; move_tick = 1'b0; abort = 1'b0;
    req_valid = 1'b0; req_row = 8'd0; req_col = 8'd0;
    rv7 = 1'b0; rr7 = 8'd0; rc7 = 8'd0;
    test_reset();
    test_move_23();
    test_step7();
    test_err();
    test_same_cell();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cell_to_pixel_mover.md
CELL_TO_PIXEL_MOVER -- requirements
Module: cell_to_pixel_mover

Interface
REQ-001 SHALL have parameter SF, default 10'd60, meaning maze cell size in pixels.
REQ-002 SHALL have parameter S_X, default 10'd150, meaning maze left-edge pixel offset.
REQ-003 SHALL have parameter S_Y, default 10'd34, meaning maze top-edge pixel offset.
REQ-004 SHALL have parameter NUM_COLS, default 8, meaning number of valid columns.
REQ-005 SHALL have parameter NUM_ROWS, default 8, meaning number of valid rows.
REQ-006 SHALL have parameter STEP, default 10'd1, meaning pixels moved per move_tick.
REQ-007 SHALL have parameters HOME_ROW and HOME_COL, default 0 each, meaning the reset cell.
REQ-008 SHALL have port clk, input, 1 bit: single system clock, all state on its rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-010 SHALL have port move_tick, input, 1 bit: one-cycle movement-rate enable.
REQ-011 SHALL have port req_valid, input, 1 bit: target-cell request strobe.
REQ-012 SHALL have ports req_row and req_col, input, 8 bits each: target cell.
REQ-013 SHALL have port abort, input, 1 bit: stop in place.
REQ-014 SHALL have port req_ready, output, 1 bit: high only in IDLE.
REQ-015 SHALL have ports xpos and ypos, output, 10 bits each: sprite top-left pixel.
REQ-016 SHALL have port direction, output, 4 bits: 1000 left, 0100 up, 0010 right, 0001 down, 0000 idle.
REQ-017 SHALL have ports done and err, output, 1 bit each: one-cycle status pulses.

Function
REQ-018 SHALL use states IDLE, CALC, MOVE_X, MOVE_Y and DONE.
REQ-019 SHALL accept a request when req_valid and req_ready are both high, latching req_row and req_col, and SHALL go to CALC.
REQ-020 SHALL ignore req_valid in all states other than IDLE.
REQ-021 In CALC, SHALL compute tx = S_X + col*SF and ty = S_Y + row*SF in 10-bit unsigned arithmetic, register both, and go to MOVE_X the next cycle.
REQ-022 In CALC, if row >= NUM_ROWS or col >= NUM_COLS, SHALL pulse err for one cycle, leave xpos, ypos and direction unchanged, and return to IDLE.
REQ-023 In MOVE_X, on each move_tick, SHALL move xpos toward tx by min(STEP, |tx - xpos|), with direction 1000 when moving left and 0010 when moving right.
REQ-024 SHALL go from MOVE_X to MOVE_Y in the cycle after xpos == tx; if already equal on entry, SHALL go to MOVE_Y without waiting for a tick.
REQ-025 In MOVE_Y, SHALL apply the same rules to ypos toward ty, with direction 0100 for up and 0001 for down, and SHALL go to DONE once ypos == ty.
REQ-026 Position SHALL never overshoot the target and SHALL never wrap below 0 or above 1023.
REQ-027 Position SHALL change only on a cycle with move_tick high.
REQ-028 DONE SHALL last one cycle, with done=1 and direction=0000, then return to IDLE.
REQ-029 A target equal to the current position SHALL give CALC, MOVE_X, MOVE_Y, DONE with no position change: done asserts 4 cycles after acceptance.
REQ-030 abort SHALL have priority over move_tick and state progress: from CALC, MOVE_X or MOVE_Y it SHALL go to IDLE next cycle, hold position, and give direction=0000 with no done.
REQ-031 direction SHALL be 0000 in IDLE, CALC and DONE, and while the current axis is at target.

Reset
REQ-032 While rst_n=0, SHALL set state to IDLE.
REQ-033 While rst_n=0, SHALL set xpos = S_X + HOME_COL*SF and ypos = S_Y + HOME_ROW*SF (150 and 34 by default).
REQ-034 While rst_n=0, SHALL set direction=0000, done=0, err=0 and req_ready=1.
REQ-035 Reset asserted mid-move SHALL discard the latched target immediately, without a clock edge.

Verification
REQ-036 Reset, then request (2,3) with move_tick every cycle -> xpos rises 150 to 330 under direction 0010, then ypos rises 34 to 154 under 0001, then one done pulse; total 300 ticks.
REQ-037 From (2,3), request (0,0) with STEP=7 -> final step sizes are 5 on x and 1 on y with no overshoot; final position is xpos=150, ypos=34 under directions 1000 then 0100.
REQ-038 Request (8,0) or (0,200) -> err pulses 2 cycles after acceptance, with no movement and no done.
REQ-039 Request the current cell -> done pulses 4 cycles after acceptance, and xpos and ypos are unchanged.
REQ-040 Abort asserted at xpos=200 together with move_tick -> xpos stays 200, next state IDLE, no done pulse; a req_valid pulsed mid-move is ignored.
REQ-041 rst_n dropped mid-move -> xpos=150, ypos=34 and req_ready=1 asynchronously, and no done pulse follows.
